// File: rtl/tst_dout_mon_cmp.sv
// Golden-compare checker: accepts the DUT AXI4-Stream, strobes the golden-ROM reader per beat, realigns and compares over GOLD_LAT.
// Error counters update GOLD_LAT+1 cycles after the accept; tready is registered and low outside RUN. Optional macro: TST_DOUT_CMP_FIRST_ERR_EN.
module tst_dout_mon_cmp #(
    parameter int DATA_BW          = 64,
    parameter int ROM_READ_LATENCY = 3,
    parameter int FRAME_LEN        = 2352,
    parameter int NUM_FRAMES       = 1,
    parameter int CNT_BW           = 14,
    parameter int ERR_BW           = 16
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               start,
    input  logic [DATA_BW-1:0] s_axis_tdata,
    input  logic               s_axis_tvalid,
    input  logic               s_axis_tlast,
    output logic               s_axis_tready,
    output logic               gold_srst,
    output logic               gold_re,
    input  logic               gold_rvld,
    input  logic [DATA_BW-1:0] gold_rdat,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_BW-1:0]  err_cnt,
    output logic               align_err,
    output logic [7:0]         frame_cnt
`ifdef TST_DOUT_CMP_FIRST_ERR_EN
    ,
    output logic               first_err_vld,
    output logic [CNT_BW-1:0]  first_err_idx,
    output logic [7:0]         first_err_frame,
    output logic [DATA_BW-1:0] first_err_dut,
    output logic [DATA_BW-1:0] first_err_gold
`endif
);

    localparam int GOLD_LAT = ROM_READ_LATENCY + 2;
    localparam int DR_BW    = $clog2(GOLD_LAT + 2);

    typedef enum logic [2:0] {S_IDLE, S_REWIND, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              r_state;
    logic                r_tready, r_gold_srst, r_busy, r_done, r_pass, r_align_err;
    logic [ERR_BW-1:0]   r_err_cnt;
    logic [7:0]          r_frame_cnt;
    logic [CNT_BW-1:0]   r_idx;
    logic [DR_BW-1:0]    r_drain_cnt;

    logic [GOLD_LAT-1:0] r_pv, r_pl, r_pe;
    logic [DATA_BW-1:0]  r_pd [GOLD_LAT];

    logic                w_accept, w_last_beat, w_dvld, w_cmp, w_data_bad, w_last_bad;
    logic                w_align_nxt, w_restart;
    logic [1:0]          w_inc;
    logic [ERR_BW:0]     w_err_sum;
    logic [ERR_BW-1:0]   w_err_nxt;

    assign w_accept    = s_axis_tvalid & r_tready;
    assign w_last_beat = (r_idx == CNT_BW'(FRAME_LEN - 1));
    assign w_dvld      = r_pv[GOLD_LAT-1];
    assign w_cmp       = w_dvld & gold_rvld;
    assign w_data_bad  = w_cmp & (r_pd[GOLD_LAT-1] != gold_rdat);
    assign w_last_bad  = w_cmp & (r_pl[GOLD_LAT-1] != r_pe[GOLD_LAT-1]);
    assign w_align_nxt = r_align_err | (gold_rvld != w_dvld);
    assign w_inc       = {1'b0, w_data_bad} + {1'b0, w_last_bad};
    assign w_err_sum   = {1'b0, r_err_cnt} + {{(ERR_BW-1){1'b0}}, w_inc};
    // Adding at most 2 to a value <= max can only overflow into the carry bit when it exceeds max.
    assign w_err_nxt   = w_err_sum[ERR_BW] ? {ERR_BW{1'b1}} : w_err_sum[ERR_BW-1:0];
    assign w_restart   = start & ((r_state == S_IDLE) | (r_state == S_DONE));

    assign s_axis_tready = r_tready;
    assign gold_srst     = r_gold_srst;
    assign gold_re       = w_accept;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_cnt       = r_err_cnt;
    assign align_err     = r_align_err;
    assign frame_cnt     = r_frame_cnt;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state     <= S_IDLE;
            r_tready    <= 1'b0;
            r_gold_srst <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_align_err <= 1'b0;
            r_err_cnt   <= '0;
            r_frame_cnt <= '0;
            r_idx       <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_gold_srst <= 1'b0;
            r_err_cnt   <= w_err_nxt;
            r_align_err <= w_align_nxt;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_err_cnt   <= '0;
                        r_align_err <= 1'b0;
                        r_frame_cnt <= '0;
                        r_pass      <= 1'b0;
                        r_done      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_gold_srst <= 1'b1;
                        r_state     <= S_REWIND;
                    end else if (r_state == S_DONE) begin
                        r_pass <= (w_err_nxt == '0) & ~w_align_nxt;
                    end
                end
                S_REWIND: begin
                    r_idx    <= '0;
                    r_tready <= 1'b1;
                    r_state  <= S_RUN;
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_idx <= r_idx + 1'b1;
                        if (w_last_beat) begin
                            r_tready    <= 1'b0;
                            r_drain_cnt <= '0;
                            r_state     <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == DR_BW'(GOLD_LAT)) begin
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                        if (r_frame_cnt + 8'd1 == 8'(NUM_FRAMES)) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_nxt == '0) & ~w_align_nxt;
                        end else begin
                            r_state     <= S_REWIND;
                            r_gold_srst <= 1'b1;
                        end
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Only the valid bits need flushing; payload stages are don't-care while invalid.
    always_ff @(posedge clk) begin
        if (srst) r_pv <= '0;
        else      r_pv <= {r_pv[GOLD_LAT-2:0], w_accept};
    end

    always_ff @(posedge clk) begin
        r_pd[0] <= s_axis_tdata;
        r_pl    <= {r_pl[GOLD_LAT-2:0], s_axis_tlast};
        r_pe    <= {r_pe[GOLD_LAT-2:0], w_last_beat};
        for (int i = 1; i < GOLD_LAT; i++) r_pd[i] <= r_pd[i-1];
    end

`ifdef TST_DOUT_CMP_FIRST_ERR_EN
    logic [CNT_BW-1:0]  r_pi [GOLD_LAT];
    logic               r_fe_vld;
    logic [CNT_BW-1:0]  r_fe_idx;
    logic [7:0]         r_fe_frame;
    logic [DATA_BW-1:0] r_fe_dut, r_fe_gold;

    always_ff @(posedge clk) begin
        r_pi[0] <= r_idx;
        for (int i = 1; i < GOLD_LAT; i++) r_pi[i] <= r_pi[i-1];
    end

    always_ff @(posedge clk) begin
        if (srst || w_restart) begin
            r_fe_vld   <= 1'b0;
            r_fe_idx   <= '0;
            r_fe_frame <= '0;
            r_fe_dut   <= '0;
            r_fe_gold  <= '0;
        end else if (w_data_bad && !r_fe_vld) begin
            r_fe_vld   <= 1'b1;
            r_fe_idx   <= r_pi[GOLD_LAT-1];
            r_fe_frame <= r_frame_cnt;
            r_fe_dut   <= r_pd[GOLD_LAT-1];
            r_fe_gold  <= gold_rdat;
        end
    end

    assign first_err_vld   = r_fe_vld;
    assign first_err_idx   = r_fe_idx;
    assign first_err_frame = r_fe_frame;
    assign first_err_dut   = r_fe_dut;
    assign first_err_gold  = r_fe_gold;
`else
    logic w_unused_restart;
    assign w_unused_restart = w_restart;
`endif

endmodule

// File: tb/tb_tst_dout_mon_cmp.sv
// Bench for tst_dout_mon_cmp: two instances (1 frame / 3 frames with a 2-bit error counter) behind golden-ROM reader models.
`timescale 1ns/1ps
module tb_tst_dout_mon_cmp;
    localparam int DW = 64;
    localparam int FL = 16;
    localparam int GL = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          srst, start1, start3, tvalid, tlast;
    logic [DW-1:0] tdata;
    logic          tready1, gsrst1, gre1, busy1, done1, pass1, aerr1, rvld1;
    logic [15:0]   err1;
    logic [7:0]    fcnt1;
    logic [DW-1:0] rdat1;
    logic          tready3, gsrst3, gre3, busy3, done3, pass3, aerr3, rvld3;
    logic [1:0]    err3;
    logic [7:0]    fcnt3;
    logic [DW-1:0] rdat3;
`ifdef TST_DOUT_CMP_FIRST_ERR_EN
    logic          fev1, fev3;
    logic [3:0]    fei1, fei3;
    logic [7:0]    fef1, fef3;
    logic [DW-1:0] fed1, feg1, fed3, feg3;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulses1 = 0, pulses3 = 0;
    logic gs1_q = 1'b0, gs3_q = 1'b0;
    bit   drop_en = 1'b0;
    int   drop_idx = 0;

    logic [DW-1:0] gold [FL];

    tst_dout_mon_cmp #(.DATA_BW(DW), .ROM_READ_LATENCY(3), .FRAME_LEN(FL), .NUM_FRAMES(1),
                       .CNT_BW(4), .ERR_BW(16)) u_dut1 (
        .clk(clk), .srst(srst), .start(start1),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .s_axis_tready(tready1),
        .gold_srst(gsrst1), .gold_re(gre1), .gold_rvld(rvld1), .gold_rdat(rdat1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .align_err(aerr1), .frame_cnt(fcnt1)
`ifdef TST_DOUT_CMP_FIRST_ERR_EN
        , .first_err_vld(fev1), .first_err_idx(fei1), .first_err_frame(fef1),
        .first_err_dut(fed1), .first_err_gold(feg1)
`endif
    );

    tst_dout_mon_cmp #(.DATA_BW(DW), .ROM_READ_LATENCY(3), .FRAME_LEN(FL), .NUM_FRAMES(3),
                       .CNT_BW(4), .ERR_BW(2)) u_dut3 (
        .clk(clk), .srst(srst), .start(start3),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .s_axis_tready(tready3),
        .gold_srst(gsrst3), .gold_re(gre3), .gold_rvld(rvld3), .gold_rdat(rdat3),
        .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3), .align_err(aerr3), .frame_cnt(fcnt3)
`ifdef TST_DOUT_CMP_FIRST_ERR_EN
        , .first_err_vld(fev3), .first_err_idx(fei3), .first_err_frame(fef3),
        .first_err_dut(fed3), .first_err_gold(feg3)
`endif
    );

    // Golden-ROM reader models: fixed GL-cycle latency, address rewinds on gold_srst.
    logic [GL-1:0] rv1 = '0, rv3 = '0;
    int ra1 [GL];
    int ra3 [GL];
    int addr1 = 0, addr3 = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (gsrst1) begin
            rv1 <= '0; addr1 <= 0;
        end else begin
            rv1 <= {rv1[GL-2:0], gre1};
            ra1[0] <= addr1;
            for (int i = GL-1; i > 0; i--) ra1[i] <= ra1[i-1];
            if (gre1) addr1 <= addr1 + 1;
        end
        if (gsrst3) begin
            rv3 <= '0; addr3 <= 0;
        end else begin
            rv3 <= {rv3[GL-2:0], gre3};
            ra3[0] <= addr3;
            for (int i = GL-1; i > 0; i--) ra3[i] <= ra3[i-1];
            if (gre3) addr3 <= addr3 + 1;
        end
    end

    assign rvld1 = rv1[GL-1] && !(drop_en && ra1[GL-1] == drop_idx);
    assign rdat1 = gold[ra1[GL-1] % FL];
    assign rvld3 = rv3[GL-1];
    assign rdat3 = gold[ra3[GL-1] % FL];

    always @(negedge clk) begin
        gs1_q <= gsrst1;
        gs3_q <= gsrst3;
        if (gsrst1 && !gs1_q) pulses1 <= pulses1 + 1;
        if (gsrst3 && !gs3_q) pulses3 <= pulses3 + 1;
    end

    task automatic new_gold();
        for (int i = 0; i < FL; i++) gold[i] = {$urandom, $urandom};
    endtask

    task automatic pulse_start(input int sel, output int start_cyc);
        start_cyc = cyc;
        if (sel == 3) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start3 = 1'b0;
    endtask

    // Streams nbeats beats following the selected instance's tready; returns the expected error count.
    task automatic drive(input int sel, input int nbeats, input int err_beat, input int last_pos,
                         input bit gaps, input int corrupt_pct, output int exp_err);
        int b = 0, guard = 0, i = 0;
        bit need = 1'b1, acc;
        logic [DW-1:0] d;
        logic l;
        exp_err = 0;
        d = '0; l = 1'b0;
        while (b < nbeats && guard < 5000) begin
            if (need) begin
                i = b % FL;
                d = gold[i];
                l = (i == last_pos);
                if (b == err_beat) d = d ^ 64'd1;
                if (corrupt_pct > 0 && $urandom_range(0, 99) < corrupt_pct) d = d ^ (64'd1 << $urandom_range(0, 63));
                if (corrupt_pct > 0 && $urandom_range(0, 99) < corrupt_pct) l = ~l;
                need = 1'b0;
            end
            if (!tvalid) tvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            tdata = d; tlast = l;
            @(negedge clk);
            acc = tvalid && ((sel == 3) ? tready3 : tready1);
            @(posedge clk); #1;
            guard++;
            if (acc) begin
                exp_err += int'(d != gold[i]) + int'(l != (i == FL-1));
                b++;
                need = 1'b1;
                if (gaps) tvalid = ($urandom_range(0, 1) != 0);
            end
        end
        tvalid = 1'b0; tlast = 1'b0;
        total++;
        if (guard >= 5000) begin
            bad++;
            $display("FAIL drive_timeout accepted=%0d required=%0d", b, nbeats);
        end
    endtask

    task automatic wait_done(input int sel, output int at_cyc);
        int n = 0;
        while (((sel == 3) ? done3 : done1) !== 1'b1 && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        at_cyc = cyc;
        total++;
        if (((sel == 3) ? done3 : done1) !== 1'b1) begin
            bad++;
            $display("FAIL done_timeout dut=%0d", sel);
        end
    endtask

    task automatic test_reset();
        srst = 1'b1; start1 = 1'b0; start3 = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0;
        repeat (4) @(posedge clk);
        #1;
        total++; if (tready1 !== 1'b0) begin bad++; $display("FAIL rst_tready got=%b want=0", tready1); end
        total++; if (gsrst1 !== 1'b1)  begin bad++; $display("FAIL rst_gold_srst got=%b want=1", gsrst1); end
        total++; if (gre1 !== 1'b0)    begin bad++; $display("FAIL rst_gold_re got=%b want=0", gre1); end
        total++; if ({busy1, done1, pass1, aerr1} !== 4'b0) begin bad++; $display("FAIL rst_flags got=%b want=0000", {busy1, done1, pass1, aerr1}); end
        total++; if (err1 !== 16'd0 || fcnt1 !== 8'd0) begin bad++; $display("FAIL rst_counts err=%0d frames=%0d want=0,0", err1, fcnt1); end
        srst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (gsrst1 !== 1'b0) begin bad++; $display("FAIL rst_gold_srst_release got=%b want=0", gsrst1); end
    endtask

    task automatic test_clean();
        int sc, dc, e;
        new_gold();
        pulses1 = 0;
        pulse_start(1, sc);
        drive(1, FL, -1, FL-1, 1'b0, 0, e);
        wait_done(1, dc);
        total++; if (dc - sc !== 24) begin bad++; $display("FAIL clean_done_latency got=%0d want=24", dc - sc); end
        total++; if (pass1 !== 1'b1) begin bad++; $display("FAIL clean_pass got=%b want=1", pass1); end
        total++; if (int'(err1) !== e) begin bad++; $display("FAIL clean_err got=%0d want=%0d", err1, e); end
        total++; if (fcnt1 !== 8'd1) begin bad++; $display("FAIL clean_frames got=%0d want=1", fcnt1); end
        total++; if (pulses1 !== 1) begin bad++; $display("FAIL clean_rewinds got=%0d want=1", pulses1); end
        total++; if (busy1 !== 1'b0 || aerr1 !== 1'b0) begin bad++; $display("FAIL clean_busy_align got=%b%b want=00", busy1, aerr1); end
    endtask

    task automatic test_data_err();
        int sc, dc, e;
        new_gold();
        pulse_start(1, sc);
        drive(1, FL, 5, FL-1, 1'b0, 0, e);
        wait_done(1, dc);
        total++; if (int'(err1) !== e || e !== 1) begin bad++; $display("FAIL data_err_cnt got=%0d want=1", err1); end
        total++; if (pass1 !== 1'b0) begin bad++; $display("FAIL data_err_pass got=%b want=0", pass1); end
`ifdef TST_DOUT_CMP_FIRST_ERR_EN
        total++; if (fev1 !== 1'b1 || fei1 !== 4'd5 || fef1 !== 8'd0) begin bad++; $display("FAIL first_err_pos vld=%b idx=%0d frame=%0d want=1,5,0", fev1, fei1, fef1); end
        total++; if (feg1 !== gold[5] || fed1 !== (gold[5] ^ 64'd1)) begin bad++; $display("FAIL first_err_data gold=%h dut=%h want=%h", feg1, fed1, gold[5]); end
`endif
    endtask

    task automatic test_early_tlast();
        int sc, dc, e;
        new_gold();
        pulse_start(1, sc);
        drive(1, FL, -1, 10, 1'b0, 0, e);
        wait_done(1, dc);
        total++; if (int'(err1) !== 2) begin bad++; $display("FAIL early_tlast_err got=%0d want=2", err1); end
        total++; if (dc - sc !== 24) begin bad++; $display("FAIL early_tlast_len got=%0d want=24", dc - sc); end
    endtask

    task automatic test_random_errors();
        int sc, dc, e;
        new_gold();
        pulse_start(1, sc);
        drive(1, FL, -1, FL-1, 1'b1, 25, e);
        wait_done(1, dc);
        total++; if (int'(err1) !== e) begin bad++; $display("FAIL random_err got=%0d want=%0d", err1, e); end
        total++; if (pass1 !== (e == 0)) begin bad++; $display("FAIL random_pass got=%b want=%b", pass1, (e == 0)); end
    endtask

    task automatic test_multi_frame();
        int sc, dc, e;
        new_gold();
        pulses3 = 0;
        pulse_start(3, sc);
        drive(3, 3*FL, -1, FL-1, 1'b1, 0, e);
        wait_done(3, dc);
        total++; if (pulses3 !== 3) begin bad++; $display("FAIL multi_rewinds got=%0d want=3", pulses3); end
        total++; if (fcnt3 !== 8'd3) begin bad++; $display("FAIL multi_frames got=%0d want=3", fcnt3); end
        total++; if (pass3 !== 1'b1 || aerr3 !== 1'b0 || err3 !== 2'd0) begin bad++; $display("FAIL multi_pass pass=%b align=%b err=%0d want=1,0,0", pass3, aerr3, err3); end
        total++; if (busy3 !== 1'b0) begin bad++; $display("FAIL multi_busy got=%b want=0", busy3); end
    endtask

    task automatic test_saturate();
        int sc, dc, e, want;
        new_gold();
        pulse_start(3, sc);
        drive(3, 3*FL, 0, FL-1, 1'b1, 50, e);
        wait_done(3, dc);
        want = (e > 3) ? 3 : e;
        total++; if (int'(err3) !== want) begin bad++; $display("FAIL sat_err got=%0d want=%0d", err3, want); end
        total++; if (pass3 !== 1'b0) begin bad++; $display("FAIL sat_pass got=%b want=0", pass3); end
    endtask

    task automatic test_align();
        int sc, dc, e;
        new_gold();
        drop_en = 1'b1; drop_idx = 7;
        pulse_start(1, sc);
        drive(1, FL, -1, FL-1, 1'b0, 0, e);
        wait_done(1, dc);
        drop_en = 1'b0;
        total++; if (aerr1 !== 1'b1) begin bad++; $display("FAIL align_flag got=%b want=1", aerr1); end
        total++; if (pass1 !== 1'b0) begin bad++; $display("FAIL align_pass got=%b want=0", pass1); end
        total++; if (err1 !== 16'd0) begin bad++; $display("FAIL align_err_cnt got=%0d want=0", err1); end
    endtask

    task automatic test_srst_mid_run();
        int sc, dc, e;
        new_gold();
        pulse_start(1, sc);
        drive(1, 8, 2, FL-1, 1'b0, 0, e);
        repeat (4) @(posedge clk);
        #1;
        srst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        srst = 1'b0;
        @(posedge clk); #1;
        total++; if (err1 !== 16'd0 || fcnt1 !== 8'd0) begin bad++; $display("FAIL srst_counts err=%0d frames=%0d want=0,0", err1, fcnt1); end
        total++; if ({busy1, done1, tready1, aerr1} !== 4'b0) begin bad++; $display("FAIL srst_flags got=%b want=0000", {busy1, done1, tready1, aerr1}); end
        pulse_start(1, sc);
        drive(1, FL, -1, FL-1, 1'b0, 0, e);
        wait_done(1, dc);
        total++; if (pass1 !== 1'b1 || err1 !== 16'd0) begin bad++; $display("FAIL srst_rerun pass=%b err=%0d want=1,0", pass1, err1); end
        total++; if (dc - sc !== 24) begin bad++; $display("FAIL srst_rerun_latency got=%0d want=24", dc - sc); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_data_err();
        test_early_tlast();
        test_random_errors();
        test_multi_frame();
        test_saturate();
        test_align();
        test_srst_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
